// File: rtl/apb_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fifo_pkg
//  Description : Register indices, bit positions and the CTRL register type
//                shared by the APB FIFO controller and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_fifo_pkg;

    // Register indices decoded from PADDR[3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_UDF_BIT   = 3;
    localparam int STATUS_CNT_LSB   = 8;

    // CTRL bit positions
    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_THR_LSB     = 8;

    typedef struct packed {
        logic [7:0] threshold;
        logic       irq_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{threshold: 8'd1, irq_en: 1'b0};

endpackage : apb_fifo_pkg
`default_nettype wire

// File: rtl/fifo_core.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_core
//  Description : Synchronous FIFO with asynchronous read of the head entry.
//                Pointers carry one extra wrap bit to tell full from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q;
    logic [AW:0]       wptr_d;
    logic [AW:0]       rptr_q;
    logic [AW:0]       rptr_d;
    logic              w_do_wr;
    logic              w_do_rd;

    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty   = (wptr_q == rptr_q);
    assign count   = wptr_q - rptr_q;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO or a pop from an empty one is simply refused,
    // so a simultaneous push+pop degrades to the one that is legal.
    assign w_do_wr = wr_en & ~full;
    assign w_do_rd = rd_en & ~empty;

    // Next pointer values
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_do_wr) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (w_do_rd) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer registers; contents of storage are irrelevant after reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write port
    always_ff @(posedge PCLK) begin
        if (w_do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule : fifo_core
`default_nettype wire

// File: rtl/apb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fifo_ctrl
//  Description : Zero-wait-state APB3 slave around fifo_core. Adds STATUS with
//                sticky W1C overflow/underflow flags, CTRL with a level
//                threshold, and a registered level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_fifo_ctrl
    import apb_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic              PWRITE,
    input  logic              PSEL,
    input  logic              PENABLE,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    logic [1:0]        w_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic              w_clr_ovf;
    logic              w_clr_udf;
    logic [DATA_W-1:0] w_rdata;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [7:0]        w_count8;
    logic [31:0]       w_status;
    logic [31:0]       w_ctrl_rd;
    logic [31:0]       w_rx;
    logic              w_unused;

    logic              ovf_q;
    logic              ovf_d;
    logic              udf_q;
    logic              udf_d;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;
    logic              irq_q;

    // A transfer commits on the edge where the access phase is active; the
    // setup phase never has side effects.
    assign w_access  = PSEL & PENABLE;
    assign w_idx     = PADDR[3:2];
    assign w_wr      = w_access & PWRITE;
    assign w_rd      = w_access & ~PWRITE;
    assign w_push    = w_wr & (w_idx == REG_TXDATA);
    assign w_pop     = w_rd & (w_idx == REG_RXDATA);
    assign w_ovf_evt = w_push & w_full;
    assign w_udf_evt = w_pop & w_empty;
    assign w_clr_ovf = w_wr & (w_idx == REG_STATUS) & PWDATA[STATUS_OVF_BIT];
    assign w_clr_udf = w_wr & (w_idx == REG_STATUS) & PWDATA[STATUS_UDF_BIT];

    assign PREADY    = w_access;
    assign PSLVERR   = w_ovf_evt | w_udf_evt;
    assign irq       = irq_q;

    // Upper PWDATA bits and undecoded address bits are intentionally ignored
    assign w_unused  = ^{PWDATA, PADDR};

    fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .wr_en  (w_push),
        .wdata  (PWDATA[DATA_W-1:0]),
        .rd_en  (w_pop),
        .rdata  (w_rdata),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    // The STATUS count field is 8 bits; deep FIFOs saturate it at 255
    generate
        if (CNT_W > 8) begin : g_cnt_sat
            assign w_count8 = (w_count > CNT_W'(255)) ? 8'hFF : w_count[7:0];
        end else begin : g_cnt_ext
            assign w_count8 = 8'(w_count);
        end
    endgenerate

    // Read data mux; PRDATA is zero outside a read access phase
    always_comb begin
        w_status                           = '0;
        w_status[STATUS_FULL_BIT]          = w_full;
        w_status[STATUS_EMPTY_BIT]         = w_empty;
        w_status[STATUS_OVF_BIT]           = ovf_q;
        w_status[STATUS_UDF_BIT]           = udf_q;
        w_status[STATUS_CNT_LSB +: 8]      = w_count8;
        w_ctrl_rd                          = '0;
        w_ctrl_rd[CTRL_IRQ_EN_BIT]         = ctrl_q.irq_en;
        w_ctrl_rd[CTRL_THR_LSB +: 8]       = ctrl_q.threshold;
        w_rx                               = '0;
        w_rx[DATA_W-1:0]                   = w_rdata;
        PRDATA                             = '0;
        if (w_rd) begin
            case (w_idx)
                REG_STATUS: PRDATA = w_status;
                REG_RXDATA: PRDATA = w_empty ? 32'h0 : w_rx;
                REG_CTRL:   PRDATA = w_ctrl_rd;
                default:    PRDATA = '0;
            endcase
        end
    end

    // Sticky flags (a set event beats a same-edge clear) and CTRL writes
    always_comb begin
        ovf_d  = w_ovf_evt | (ovf_q & ~w_clr_ovf);
        udf_d  = w_udf_evt | (udf_q & ~w_clr_udf);
        ctrl_d = ctrl_q;
        if (w_wr && (w_idx == REG_CTRL)) begin
            ctrl_d.irq_en    = PWDATA[CTRL_IRQ_EN_BIT];
            ctrl_d.threshold = PWDATA[CTRL_THR_LSB +: 8];
        end
    end

    // Flag/CTRL state, and the interrupt registered from the committed state
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            ctrl_q <= CTRL_RESET;
            irq_q  <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            ctrl_q <= ctrl_d;
            irq_q  <= ctrl_q.irq_en & ((w_count8 >= ctrl_q.threshold) | ovf_q | udf_q);
        end
    end

endmodule : apb_fifo_ctrl
`default_nettype wire

// File: tb/tb_apb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_fifo_ctrl
//  Description : Self-checking bench for apb_fifo_ctrl: a vector table, hand
//                sequences for full/irq/wrap/reset, and a randomized run
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    localparam logic [1:0] A_ST = 2'd0;
    localparam logic [1:0] A_TX = 2'd1;
    localparam logic [1:0] A_RX = 2'd2;
    localparam logic [1:0] A_CT = 2'd3;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic [ADDR_W-1:0] PADDR = '0;
    logic [31:0]       PWDATA = '0;
    logic              PWRITE = 1'b0;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_fifo_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq     (irq)
    );

    typedef struct {
        bit          wr;
        logic [1:0]  idx;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_udf;
    bit         m_en;
    int         m_thr;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = 32'h0;
        s[0]    = (mq.size() == DEPTH);
        s[1]    = (mq.size() == 0);
        s[2]    = m_ovf;
        s[3]    = m_udf;
        s[15:8] = 8'(mq.size());
        return s;
    endfunction

    function automatic logic m_irq();
        return m_en && ((mq.size() >= m_thr) || m_ovf || m_udf);
    endfunction

    function automatic void add(bit wr, logic [1:0] idx, logic [31:0] wd,
                                logic [31:0] exp_rd, logic exp_err, string nm);
        vec_t v;
        v.wr = wr; v.idx = idx; v.wd = wd; v.exp_rd = exp_rd; v.exp_err = exp_err; v.nm = nm;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // One APB transfer, entered and left at posedge+1. Returns irq as seen
    // during the access phase.
    task automatic do_op(input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                         input bit keep, input logic [31:0] exp_rd, input logic exp_err,
                         input string nm, output logic irq_s);
        logic [31:0] rd;
        logic        err;
        logic        rdy_s;
        logic        rdy_a;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = {idx, 2'($urandom_range(0, 3))};
        PWDATA  = wd;
        @(negedge PCLK);
        rdy_s = PREADY;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        rd    = PRDATA;
        err   = PSLVERR;
        rdy_a = PREADY;
        irq_s = irq;
        @(posedge PCLK); #1;
        PENABLE = 1'b0;
        if (!keep) PSEL = 1'b0;
        chk({nm, "_prdata"}, rd, exp_rd);
        chk_b({nm, "_pslverr"}, err, exp_err);
        chk_b({nm, "_pready"}, rdy_a, 1'b1);
        chk_b({nm, "_setup_pready"}, rdy_s, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        irq_s;
        logic [7:0]  wq[$];
        logic [7:0]  d;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_irq;
        int          r;
        int          pu;
        int          thr;
        bit          en;

        // ---------------- reset ----------------
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk_b("idle_pready", PREADY, 1'b0);
        chk_b("reset_irq", irq, 1'b0);
        chk("idle_prdata", PRDATA, 32'h0);
        chk_b("idle_pslverr", PSLVERR, 1'b0);
        @(posedge PCLK); #1;
        do_op(1'b0, A_ST, 32'h0, 1'b0, 32'h0000_0002, 1'b0, "reset_status", irq_s);

        // ---------------- vector table ----------------
        add(1'b0, A_CT, 32'h0,   32'h0000_0100, 1'b0, "ctrl_reset");
        add(1'b1, A_TX, 32'hA1,  32'h0,         1'b0, "push_a1");
        add(1'b0, A_ST, 32'h0,   32'h0000_0100, 1'b0, "st_cnt1");
        add(1'b1, A_TX, 32'hB2,  32'h0,         1'b0, "push_b2");
        add(1'b0, A_ST, 32'h0,   32'h0000_0200, 1'b0, "st_cnt2");
        add(1'b1, A_TX, 32'hC3,  32'h0,         1'b0, "push_c3");
        add(1'b0, A_ST, 32'h0,   32'h0000_0300, 1'b0, "st_cnt3");
        add(1'b0, A_TX, 32'h0,   32'h0,         1'b0, "txdata_read");
        add(1'b1, A_RX, 32'h55,  32'h0,         1'b0, "rxdata_write");
        add(1'b0, A_ST, 32'h0,   32'h0000_0300, 1'b0, "st_cnt3_again");
        add(1'b0, A_RX, 32'h0,   32'h0000_00A1, 1'b0, "pop_a1");
        add(1'b0, A_ST, 32'h0,   32'h0000_0200, 1'b0, "st_cnt2b");
        add(1'b0, A_RX, 32'h0,   32'h0000_00B2, 1'b0, "pop_b2");
        add(1'b0, A_ST, 32'h0,   32'h0000_0100, 1'b0, "st_cnt1b");
        add(1'b0, A_RX, 32'h0,   32'h0000_00C3, 1'b0, "pop_c3");
        add(1'b0, A_ST, 32'h0,   32'h0000_0002, 1'b0, "st_empty");
        add(1'b0, A_RX, 32'h0,   32'h0,         1'b1, "pop_empty");
        add(1'b0, A_ST, 32'h0,   32'h0000_000A, 1'b0, "st_udf");
        add(1'b1, A_ST, 32'h0,   32'h0,         1'b0, "w1c_zero");
        add(1'b0, A_ST, 32'h0,   32'h0000_000A, 1'b0, "st_udf_kept");
        add(1'b1, A_ST, 32'hC,   32'h0,         1'b0, "w1c_clear");
        add(1'b0, A_ST, 32'h0,   32'h0000_0002, 1'b0, "st_cleared");
        for (int i = 0; i < tbl.size(); i++) begin
            do_op(tbl[i].wr, tbl[i].idx, tbl[i].wd, (i != tbl.size() - 1),
                  tbl[i].exp_rd, tbl[i].exp_err, tbl[i].nm, irq_s);
            chk_b({tbl[i].nm, "_irq"}, irq_s, 1'b0);
        end

        // ---------------- fill, overflow, drain ----------------
        for (int i = 0; i < DEPTH; i++)
            do_op(1'b1, A_TX, 32'(i), 1'b1, 32'h0, 1'b0, "fill", irq_s);
        do_op(1'b0, A_ST, 32'h0, 1'b1, 32'h0000_1001, 1'b0, "st_full", irq_s);
        do_op(1'b1, A_TX, 32'hFF, 1'b1, 32'h0, 1'b1, "push_full", irq_s);
        do_op(1'b0, A_ST, 32'h0, 1'b1, 32'h0000_1005, 1'b0, "st_ovf", irq_s);
        for (int i = 0; i < DEPTH; i++)
            do_op(1'b0, A_RX, 32'h0, 1'b1, 32'(i), 1'b0, "drain", irq_s);
        do_op(1'b0, A_ST, 32'h0, 1'b1, 32'h0000_0006, 1'b0, "st_drained", irq_s);
        do_op(1'b1, A_ST, 32'h4, 1'b1, 32'h0, 1'b0, "clr_ovf", irq_s);
        do_op(1'b0, A_ST, 32'h0, 1'b0, 32'h0000_0002, 1'b0, "st_ovf_clr", irq_s);

        // ---------------- level interrupt ----------------
        do_op(1'b1, A_CT, 32'h0000_0401, 1'b0, 32'h0, 1'b0, "ctrl_wr", irq_s);
        do_op(1'b0, A_CT, 32'h0, 1'b0, 32'h0000_0401, 1'b0, "ctrl_rd", irq_s);
        for (int i = 0; i < 3; i++)
            do_op(1'b1, A_TX, 32'(16 + i), 1'b0, 32'h0, 1'b0, "irq_push", irq_s);
        repeat (2) @(posedge PCLK); #1;
        chk_b("irq_below_thr", irq, 1'b0);
        do_op(1'b1, A_TX, 32'h13, 1'b0, 32'h0, 1'b0, "irq_push4", irq_s);
        chk_b("irq_at_commit", irq, 1'b0);
        @(posedge PCLK); #1;
        chk_b("irq_after_commit", irq, 1'b1);
        do_op(1'b0, A_RX, 32'h0, 1'b0, 32'h10, 1'b0, "irq_pop", irq_s);
        chk_b("irq_hold_at_pop", irq, 1'b1);
        @(posedge PCLK); #1;
        chk_b("irq_clear_after_pop", irq, 1'b0);
        do_op(1'b1, A_CT, 32'h0000_0001, 1'b0, 32'h0, 1'b0, "ctrl_thr0", irq_s);
        for (int i = 0; i < 3; i++)
            do_op(1'b0, A_RX, 32'h0, 1'b0, 32'(17 + i), 1'b0, "thr0_pop", irq_s);
        repeat (2) @(posedge PCLK); #1;
        chk_b("irq_thr0_empty", irq, 1'b1);
        do_op(1'b1, A_CT, 32'h0, 1'b0, 32'h0, 1'b0, "ctrl_off", irq_s);
        repeat (2) @(posedge PCLK); #1;
        chk_b("irq_disabled", irq, 1'b0);

        // ---------------- pointer wrap ----------------
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            wq.push_back(d);
            do_op(1'b1, A_TX, {24'h0, d}, 1'b1, 32'h0, 1'b0, "wrap_prefill", irq_s);
        end
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            wq.push_back(d);
            do_op(1'b1, A_TX, {24'h0, d}, 1'b1, 32'h0, 1'b0, "wrap_push", irq_s);
            d = wq.pop_front();
            do_op(1'b0, A_RX, 32'h0, 1'b1, {24'h0, d}, 1'b0, "wrap_pop", irq_s);
            do_op(1'b0, A_ST, 32'h0, 1'b1, 32'h0000_0800, 1'b0, "wrap_status", irq_s);
        end
        for (int i = 0; i < 3; i++) begin
            d = wq.pop_front();
            do_op(1'b0, A_RX, 32'h0, 1'b1, {24'h0, d}, 1'b0, "wrap_tail", irq_s);
        end
        do_op(1'b0, A_ST, 32'h0, 1'b0, 32'h0000_0500, 1'b0, "st_cnt5", irq_s);

        // ---------------- reset in the middle of an access ----------------
        do_op(1'b1, A_CT, 32'h0000_0101, 1'b0, 32'h0, 1'b0, "ctrl_en", irq_s);
        repeat (2) @(posedge PCLK); #1;
        chk_b("pre_reset_irq", irq, 1'b1);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {A_TX, 2'b00}; PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        chk_b("reset_irq_async", irq, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        do_op(1'b0, A_ST, 32'h0, 1'b0, 32'h0000_0002, 1'b0, "post_reset_status", irq_s);
        chk_b("post_reset_irq", irq_s, 1'b0);
        do_op(1'b0, A_CT, 32'h0, 1'b0, 32'h0000_0100, 1'b0, "post_reset_ctrl", irq_s);
        do_op(1'b0, A_RX, 32'h0, 1'b0, 32'h0, 1'b1, "post_reset_empty", irq_s);
        do_op(1'b1, A_ST, 32'hC, 1'b0, 32'h0, 1'b0, "post_reset_clr", irq_s);

        // ---------------- randomized run against the model ----------------
        m_ovf = 1'b0; m_udf = 1'b0; m_en = 1'b0; m_thr = 1;
        for (int i = 0; i < 400; i++) begin
            r       = $urandom_range(0, 99);
            pu      = (((i / 100) % 2) == 0) ? 55 : 25;
            exp_irq = m_irq();
            if (r < pu) begin
                wd      = $urandom;
                exp_err = (mq.size() == DEPTH);
                do_op(1'b1, A_TX, wd, 1'b1, 32'h0, exp_err, "rnd_push", irq_s);
                if (exp_err) m_ovf = 1'b1;
                else         mq.push_back(wd[7:0]);
            end else if (r < 80) begin
                exp_err = (mq.size() == 0);
                exp_rd  = exp_err ? 32'h0 : {24'h0, mq[0]};
                do_op(1'b0, A_RX, $urandom, 1'b1, exp_rd, exp_err, "rnd_pop", irq_s);
                if (exp_err) m_udf = 1'b1;
                else         d = mq.pop_front();
            end else if (r < 85) begin
                do_op(1'b0, A_ST, $urandom, 1'b1, m_status(), 1'b0, "rnd_status", irq_s);
            end else if (r < 89) begin
                wd = $urandom;
                do_op(1'b1, A_ST, wd, 1'b1, 32'h0, 1'b0, "rnd_w1c", irq_s);
                if (wd[2]) m_ovf = 1'b0;
                if (wd[3]) m_udf = 1'b0;
            end else if (r < 93) begin
                thr = $urandom_range(0, 20);
                en  = 1'($urandom_range(0, 1));
                wd  = {16'($urandom), 8'(thr), 7'($urandom), en};
                do_op(1'b1, A_CT, wd, 1'b1, 32'h0, 1'b0, "rnd_ctrl_wr", irq_s);
                m_thr = thr;
                m_en  = en;
            end else if (r < 96) begin
                do_op(1'b0, A_CT, $urandom, 1'b1,
                      {16'h0, 8'(m_thr), 7'h0, m_en}, 1'b0, "rnd_ctrl_rd", irq_s);
            end else if (r < 98) begin
                do_op(1'b0, A_TX, $urandom, 1'b1, 32'h0, 1'b0, "rnd_tx_read", irq_s);
            end else begin
                do_op(1'b1, A_RX, $urandom, 1'b1, 32'h0, 1'b0, "rnd_rx_write", irq_s);
            end
            chk_b("rnd_irq", irq_s, exp_irq);
        end
        PSEL = 1'b0;
        @(posedge PCLK); #1;
        do_op(1'b0, A_ST, 32'h0, 1'b0, m_status(), 1'b0, "final_status", irq_s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_apb_fifo_ctrl
`default_nettype wire

// File: doc/apb_fifo_ctrl.md
Name: apb_fifo_ctrl

Overview:
- APB3 slave peripheral wrapping a parametrised synchronous FIFO (width DATA_W, depth DEPTH).
- Each completed APB transfer causes exactly one push or pop. No repeated pushes or pops while PSEL is held.
- Adds an occupancy count, sticky overflow/underflow flags, a programmable level threshold and a level interrupt.
- Sits on the APB bus beside the other peripherals; the CPU uses it as a TX/RX mailbox.

Parameters:
- DATA_W, 8, FIFO word width (1..32). Upper PRDATA bits read 0.
- DEPTH, 16, entry count. Must be a power of two, >= 2.
- ADDR_W, 4, PADDR width. Only PADDR[3:2] is decoded.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset, asynchronous, active-high.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  32  write data.
- PWRITE  in  1  1 = write.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- irq  out  1  level interrupt.

Behaviour:
- Register map (PADDR[3:2]):
  - 0 STATUS: RO except W1C bits. [0] full, [1] empty, [2] ovf (W1C), [3] udf (W1C), [15:8] count.
  - 1 TXDATA: WO. A write pushes PWDATA[DATA_W-1:0]. Reads return 0.
  - 2 RXDATA: RO. A read returns the head word and pops. Writes are ignored.
  - 3 CTRL: RW. [0] irq_en, [15:8] threshold. Other bits read 0.
- Reset values:
  - FIFO empty, count=0, ovf=udf=0, irq_en=0, threshold=1.
  - PRDATA=0, PSLVERR=0, irq=0.
- APB timing:
  - Zero wait states: PREADY=1 combinationally whenever PSEL&PENABLE, otherwise 0.
  - The transfer commits on the PCLK edge where PSEL&PENABLE is high. The setup phase has no side effects.
  - PRDATA is combinational during the access phase and 0 outside it. RXDATA reads present the head word combinationally; the pointer advances at the commit edge.
- Push, when full:
  - Data is dropped, ovf=1, PSLVERR=1 for that transfer.
  - Pointers and storage are unchanged.
- Pop, when empty:
  - PRDATA=0, udf=1, PSLVERR=1.
  - Pointers are unchanged.
- Pointers and count:
  - Read/write pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit.
  - full = (addr bits equal) && (MSBs differ). empty = pointers equal.
  - count = wptr - rptr, modulo 2^(CNT_W), range 0..DEPTH, zero-extended into [15:8].
  - count is saturated at 255 in the field if DEPTH > 255.
- Only one APB transfer commits per cycle, so simultaneous push and pop on the bus cannot occur. The core still supports wr_en&rd_en in the same cycle: both pointers advance, count is unchanged, and this is legal when neither full nor empty. If the FIFO is empty, only the push takes effect; if full, only the pop.
- W1C rules:
  - Writing 1 to STATUS[2] or STATUS[3] clears that flag. Writing 0 has no effect.
  - If a set event and a clear land on the same edge, set wins.
- Interrupt:
  - irq = irq_en & ((count >= threshold) | ovf | udf). It is registered: it updates one cycle after the commit edge.
  - threshold = 0 means irq_en alone asserts irq.
- Reset mid-transfer aborts the transfer. Storage contents are don't-care after reset; pointers reset to 0.

Decomposition:
- Package apb_fifo_pkg holds:
  - localparams for register indices (REG_STATUS=0, REG_TXDATA=1, REG_RXDATA=2, REG_CTRL=3);
  - STATUS/CTRL bit positions;
  - typedef for the CTRL register struct (irq_en, threshold).
- One sub-module, fifo_core #(DATA_W, DEPTH):
  - ports PCLK, PRESET, wr_en, wdata, rd_en, rdata, full, empty, count;
  - contains storage with async read and the pointer logic.
- APB decode, flags, CTRL and irq stay in apb_fifo_ctrl.

Test Plan:
- Reset, then read STATUS -> 0x0000_0002 (empty=1, count=0). irq=0, PREADY=0 while idle.
- Write TXDATA 0xA1, 0xB2, 0xC3, then read RXDATA three times -> 0xA1, 0xB2, 0xC3. STATUS count steps 1,2,3,2,1,0. Exactly one push per transfer, even with PSEL held across back-to-back transfers.
- Push 16 words 0x00..0x0F -> STATUS=0x1001. 17th write 0xFF -> PSLVERR=1, STATUS=0x1005. Drain 16 words -> 0x00..0x0F; 0xFF is never seen.
- Pop when empty -> PRDATA=0, PSLVERR=1, STATUS bit3=1. Write STATUS 0x0000_000C -> ovf=udf=0.
- CTRL=0x0000_0401 (threshold 4, irq_en), push 3 -> irq=0; 4th push -> irq=1 one cycle after commit; pop 1 -> irq=0.
- Wrap test: 40 push/pop pairs interleaved at count 8 -> data order preserved across pointer wrap, full and empty never falsely set. Assert PRESET mid-access with count=5 -> STATUS=0x0000_0002, irq=0 immediately.
